neuron_multilane: RTL and testbench

Parametrised successor to the single-neuron block. Computes out = act(sat(bias + sum(inputs[i]*weights[i]))) over NUM_INPUTS fixed-point operands, processing LANES products per clock in a time-multiplexed MAC. The weights and bias are per-run ports, and the activation is selectable. It sits inside layer wrappers, one instance per neuron, driven by the layer sequencer's inputs_ready strobe.

---
 rtl/neuron_multilane_pkg.sv | 24 ++
 rtl/neuron_multilane_activation.sv | 36 +++
 rtl/neuron_multilane.sv | 130 +++++++++++++
 tb/tb_neuron_multilane.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_multilane_pkg.sv
// rtl/neuron_multilane_pkg.sv - fixed-point types and constants shared by neuron blocks
package neuron_multilane_pkg;

  localparam int INTEGRAL_WIDTH = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int FIXED_WIDTH    = INTEGRAL_WIDTH + FRACTION_WIDTH;

  // Signed two's-complement value; integral carries the sign.
  typedef struct packed {
    logic signed [INTEGRAL_WIDTH-1:0] integral;
    logic        [FRACTION_WIDTH-1:0] fraction;
  } fixed_point;

  typedef enum logic [1:0] {
    IDENTITY   = 2'd0,
    RELU       = 2'd1,
    LEAKY_RELU = 2'd2
  } activation_type;

  localparam logic [FIXED_WIDTH-1:0] FIXED_MAX = 16'h7FFF;
  localparam logic [FIXED_WIDTH-1:0] FIXED_MIN = 16'h8000;
  localparam int                     LEAKY_SHIFT = 3;

endpackage

// File: rtl/neuron_multilane_activation.sv
// rtl/neuron_multilane_activation.sv - saturate a wide signed value to fixed_point and apply activation
//
// Ports:
//   value  : wide signed value already aligned to fixed_point scaling (fraction LSB at bit 0)
//   result : saturated value after the selected activation
module activation_unit
  import neuron_multilane_pkg::*;
#(
  parameter int             IN_W       = 32,
  parameter activation_type ACTIVATION = RELU
) (
  input  logic [IN_W-1:0]        value,
  output logic [FIXED_WIDTH-1:0] result
);

  logic                          overflow;
  logic signed [FIXED_WIDTH-1:0] sat;
  logic signed [FIXED_WIDTH-1:0] leaky;

  always_comb begin
    // Fits in FIXED_WIDTH only if every bit above the target sign bit copies the sign.
    overflow = (value[IN_W-1:FIXED_WIDTH-1] != {(IN_W-FIXED_WIDTH+1){value[IN_W-1]}});
    if (overflow) begin
      sat = value[IN_W-1] ? FIXED_MIN : FIXED_MAX;
    end else begin
      sat = value[FIXED_WIDTH-1:0];
    end
    leaky = sat >>> LEAKY_SHIFT;
    case (ACTIVATION)
      RELU:       result = sat[FIXED_WIDTH-1] ? '0 : sat;
      LEAKY_RELU: result = sat[FIXED_WIDTH-1] ? leaky : sat;
      default:    result = sat;
    endcase
  end

endmodule

// File: rtl/neuron_multilane.sv
// rtl/neuron_multilane.sv - time-multiplexed multi-lane fixed-point neuron
//
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   inputs_ready   : start strobe; operands sampled when idle or done
//   inputs/weights : NUM_INPUTS packed fixed_point operands, element i at [i*16 +: 16]
//   bias           : fixed_point bias
//   busy           : run in progress (accumulate/activate)
//   output_ready   : out holds a valid result
//   out            : registered result
module neuron_multilane
  import neuron_multilane_pkg::*;
#(
  parameter int             NUM_INPUTS = 16,
  parameter int             LANES      = 4,
  parameter activation_type ACTIVATION = RELU
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              inputs_ready,
  input  logic [NUM_INPUTS*FIXED_WIDTH-1:0] inputs,
  input  logic [NUM_INPUTS*FIXED_WIDTH-1:0] weights,
  input  logic [FIXED_WIDTH-1:0]            bias,
  output logic                              busy,
  output logic                              output_ready,
  output logic [FIXED_WIDTH-1:0]            out
);

  localparam int W       = FIXED_WIDTH;
  localparam int CHUNKS  = (NUM_INPUTS + LANES - 1) / LANES;
  localparam int CW      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int ACC_W   = 2*W + $clog2(NUM_INPUTS+1) + 1;
  localparam int SHIFT_W = ACC_W - FRACTION_WIDTH;
  localparam int PAD_W   = CHUNKS*LANES*W;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ACCUMULATE = 2'd1;
  localparam logic [1:0] ST_ACTIVATE   = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  logic [1:0]              state;
  logic [CW-1:0]           chunk;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] chunk_sum;
  logic signed [2*W-1:0]   prod;
  logic [W-1:0]            act_result;
  logic                    accept;
  logic                    acc_frac_unused;

  // Operands stored chunk-major so the lane mux indexes only by chunk.
  logic signed [W-1:0] in_q [CHUNKS][LANES];
  logic signed [W-1:0] w_q  [CHUNKS][LANES];

  // Zero-padding to a whole number of chunks makes the tail lanes contribute 0.
  logic [PAD_W-1:0] in_pad;
  logic [PAD_W-1:0] w_pad;
  assign in_pad = PAD_W'(inputs);
  assign w_pad  = PAD_W'(weights);

  assign accept = inputs_ready && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int c = 0; c < CHUNKS; c++) begin
        for (int l = 0; l < LANES; l++) begin
          in_q[c][l] <= in_pad[(c*LANES+l)*W +: W];
          w_q[c][l]  <= w_pad[(c*LANES+l)*W +: W];
        end
      end
    end
  end

  always_comb begin
    chunk_sum = '0;
    prod      = '0;
    for (int l = 0; l < LANES; l++) begin
      prod      = in_q[chunk][l] * w_q[chunk][l];
      chunk_sum = chunk_sum + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    end
  end

  // Dropping the fraction bits is the arithmetic shift (floor toward -inf).
  activation_unit #(
    .IN_W       (SHIFT_W),
    .ACTIVATION (ACTIVATION)
  ) u_act (
    .value  (acc[ACC_W-1:FRACTION_WIDTH]),
    .result (act_result)
  );
  assign acc_frac_unused = ^acc[FRACTION_WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      chunk        <= '0;
      acc          <= '0;
      busy         <= 1'b0;
      output_ready <= 1'b0;
      out          <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (inputs_ready) begin
            acc          <= ACC_W'({{(ACC_W-W){bias[W-1]}}, bias}) << FRACTION_WIDTH;
            chunk        <= '0;
            state        <= ST_ACCUMULATE;
            busy         <= 1'b1;
            output_ready <= 1'b0;
          end
        end
        ST_ACCUMULATE: begin
          acc <= acc + chunk_sum;
          if (chunk == CW'(CHUNKS-1)) begin
            state <= ST_ACTIVATE;
          end else begin
            chunk <= chunk + 1'b1;
          end
        end
        ST_ACTIVATE: begin
          out          <= act_result;
          output_ready <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_multilane.sv
// tb/tb_neuron_multilane.sv - self-checking bench for neuron_multilane across several configurations
module tb_neuron_multilane;
  import neuron_multilane_pkg::*;

  localparam int ND = 6;
  localparam int N_OF   [ND] = '{16, 16, 16, 10, 10, 10};
  localparam int L_OF   [ND] = '{4, 4, 4, 4, 1, 10};
  localparam int ACT_OF [ND] = '{0, 1, 2, 0, 0, 0};

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              inputs_ready = 1'b0;
  logic [16*16-1:0]  ins = '0;
  logic [16*16-1:0]  wts = '0;
  logic [15:0]       bias = '0;
  logic [ND-1:0]     rdy;
  logic [ND-1:0]     bsy;
  logic [ND-1:0][15:0] o;

  int checks = 0;
  int failures = 0;
  logic [15:0] expv [ND];
  int lat [ND];
  int bcnt [ND];

  always #5 clock = ~clock;

  neuron_multilane #(.NUM_INPUTS(16), .LANES(4), .ACTIVATION(IDENTITY)) d0 (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(ins), .weights(wts),
    .bias(bias), .busy(bsy[0]), .output_ready(rdy[0]), .out(o[0]));
  neuron_multilane #(.NUM_INPUTS(16), .LANES(4), .ACTIVATION(RELU)) d1 (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(ins), .weights(wts),
    .bias(bias), .busy(bsy[1]), .output_ready(rdy[1]), .out(o[1]));
  neuron_multilane #(.NUM_INPUTS(16), .LANES(4), .ACTIVATION(LEAKY_RELU)) d2 (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(ins), .weights(wts),
    .bias(bias), .busy(bsy[2]), .output_ready(rdy[2]), .out(o[2]));
  neuron_multilane #(.NUM_INPUTS(10), .LANES(4), .ACTIVATION(IDENTITY)) d3 (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(ins[159:0]), .weights(wts[159:0]),
    .bias(bias), .busy(bsy[3]), .output_ready(rdy[3]), .out(o[3]));
  neuron_multilane #(.NUM_INPUTS(10), .LANES(1), .ACTIVATION(IDENTITY)) d4 (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(ins[159:0]), .weights(wts[159:0]),
    .bias(bias), .busy(bsy[4]), .output_ready(rdy[4]), .out(o[4]));
  neuron_multilane #(.NUM_INPUTS(10), .LANES(10), .ACTIVATION(IDENTITY)) d5 (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(ins[159:0]), .weights(wts[159:0]),
    .bias(bias), .busy(bsy[5]), .output_ready(rdy[5]), .out(o[5]));

  typedef struct {
    logic [15:0] in_v;
    logic [15:0] w_v;
    logic [15:0] b_v;
    logic [15:0] e_id;
    logic [15:0] e_relu;
    logic [15:0] e_leaky;
    logic [15:0] e_10;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int d, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h want=%0h", name, d, act, exp);
    end
  endtask

  function automatic int chunks_of(int d);
    return (N_OF[d] + L_OF[d] - 1) / L_OF[d];
  endfunction

  // Plain integer arithmetic: exact sum, floor to fixed point, clamp, activation.
  function automatic logic [15:0] model(int d);
    longint acc;
    acc = longint'($signed(bias)) * 256;
    for (int i = 0; i < N_OF[d]; i++)
      acc += longint'($signed(ins[i*16 +: 16])) * longint'($signed(wts[i*16 +: 16]));
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (ACT_OF[d] == 1 && acc < 0) acc = 0;
    if (ACT_OF[d] == 2 && acc < 0) acc = acc >>> 3;
    return acc[15:0];
  endfunction

  task automatic scramble();
    for (int i = 0; i < 16; i++) begin
      ins[i*16 +: 16] = 16'($urandom);
      wts[i*16 +: 16] = 16'($urandom);
    end
    bias = 16'($urandom);
  endtask

  // Pulses inputs_ready once, garbles the operand ports right after the
  // accept edge, then checks result, latency and busy length on every instance.
  task automatic run_and_check(input string tag);
    @(negedge clock);
    inputs_ready = 1'b1;
    @(posedge clock);
    #1;
    inputs_ready = 1'b0;
    scramble();
    for (int d = 0; d < ND; d++) begin
      lat[d] = -1;
      bcnt[d] = 0;
    end
    @(negedge clock);
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_ready_drop"}, d, rdy[d], 0);
      if (bsy[d]) bcnt[d]++;
    end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock);
      @(negedge clock);
      for (int d = 0; d < ND; d++) begin
        if (rdy[d] && lat[d] < 0) lat[d] = k;
        if (bsy[d]) bcnt[d]++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_out"}, d, o[d], expv[d]);
      chk({tag, "_latency"}, d, lat[d], chunks_of(d) + 1);
      chk({tag, "_busy_cycles"}, d, bcnt[d], chunks_of(d) + 1);
    end
  endtask

  task automatic load_row(input vec_t v);
    ins = {16{v.in_v}};
    wts = {16{v.w_v}};
    bias = v.b_v;
    expv[0] = v.e_id;
    expv[1] = v.e_relu;
    expv[2] = v.e_leaky;
    for (int d = 3; d < ND; d++) expv[d] = v.e_10;
  endtask

  initial begin
    int k1, k2;
    logic [15:0] v1, v2;
    logic prev;

    tbl[0] = '{16'h0100, 16'h0080, 16'h0000, 16'h0800, 16'h0800, 16'h0800, 16'h0500};
    tbl[1] = '{16'h0100, 16'hFFC0, 16'h0000, 16'hFC00, 16'h0000, 16'hFF80, 16'hFD80};
    tbl[2] = '{16'h1000, 16'h1000, 16'h0100, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbl[3] = '{16'h1000, 16'hF000, 16'h0000, 16'h8000, 16'h0000, 16'hF000, 16'h8000};
    tbl[4] = '{16'h0100, 16'h0100, 16'h0080, 16'h1080, 16'h1080, 16'h1080, 16'h0A80};
    tbl[5] = '{16'h0100, 16'hFFFF, 16'h0000, 16'hFFF0, 16'h0000, 16'hFFFE, 16'hFFF6};
    tbl[6] = '{16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF};
    tbl[7] = '{16'h0000, 16'h0000, 16'hFF00, 16'hFF00, 16'h0000, 16'hFFE0, 16'hFF00};

    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < ND; d++) begin
      chk("reset_out", d, o[d], 0);
      chk("reset_ready", d, rdy[d], 0);
      chk("reset_busy", d, bsy[d], 0);
    end
    reset = 1'b0;

    for (int t = 0; t < 8; t++) begin
      load_row(tbl[t]);
      run_and_check($sformatf("vec%0d", t));
    end

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) begin
        if (r < 5) begin
          ins[i*16 +: 16] = 16'($signed($urandom_range(0, 2047)) - 1024);
          wts[i*16 +: 16] = 16'($signed($urandom_range(0, 2047)) - 1024);
        end else begin
          ins[i*16 +: 16] = 16'($urandom);
          wts[i*16 +: 16] = 16'($urandom);
        end
      end
      bias = 16'($urandom);
      for (int d = 0; d < ND; d++) expv[d] = model(d);
      run_and_check($sformatf("rand%0d", r));
    end

    // Continuous inputs_ready: first result uses the captured operands,
    // restart happens on the first DONE edge and picks up the new ones.
    load_row(tbl[0]);
    @(negedge clock);
    inputs_ready = 1'b1;
    @(posedge clock);
    #1;
    ins = {16{tbl[1].in_v}};
    wts = {16{tbl[1].w_v}};
    bias = tbl[1].b_v;
    k1 = -1; k2 = -1; v1 = '0; v2 = '0; prev = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (rdy[0] && !prev) begin
        if (k1 < 0) begin k1 = k; v1 = o[0]; end
        else if (k2 < 0) begin k2 = k; v2 = o[0]; end
      end
      prev = rdy[0];
    end
    inputs_ready = 1'b0;
    chk("hold_first_out", 0, v1, 16'h0800);
    chk("hold_first_latency", 0, k1, 5);
    chk("hold_gap_cycles", 0, k2 - k1 - 1, 5);
    chk("hold_second_out", 0, v2, 16'hFC00);
    repeat (30) @(posedge clock);

    // Reset two chunks into a run, then a clean run afterwards.
    load_row(tbl[0]);
    @(negedge clock);
    inputs_ready = 1'b1;
    @(posedge clock);
    #1;
    inputs_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < ND; d++) begin
      chk("midrun_reset_out", d, o[d], 0);
      chk("midrun_reset_ready", d, rdy[d], 0);
      chk("midrun_reset_busy", d, bsy[d], 0);
    end
    reset = 1'b0;
    load_row(tbl[0]);
    run_and_check("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
